// File: rtl/img_bram_sequencer.sv
// Frame phase sequencer and arbiter for the shared single-port image BRAM.
// The current phase owner and the debug port share the BRAM round-robin; stalled phases time out to ERR.
module img_bram_sequencer #(
    parameter int ADDR_W  = 14,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 2_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              rx_done,
    input  logic              proc_done,
    input  logic              tx_done,
    input  logic              rx_req,
    input  logic              proc_req,
    input  logic              tx_req,
    input  logic              dbg_req,
    input  logic              proc_we,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] rx_addr,
    input  logic [ADDR_W-1:0] proc_addr,
    input  logic [ADDR_W-1:0] tx_addr,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] rx_wdata,
    input  logic [DATA_W-1:0] proc_wdata,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              rx_gnt,
    output logic              proc_gnt,
    output logic              tx_gnt,
    output logic              dbg_gnt,
    output logic              rd_valid,
    output logic [1:0]        rd_src,
    output logic [DATA_W-1:0] rd_data,
    output logic              bram_ena,
    output logic              bram_wea,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_din,
    input  logic [DATA_W-1:0] bram_dout,
    output logic [2:0]        phase,
    output logic              proc_start,
    output logic              tx_start,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        PROC = 3'd2,
        DUMP = 3'd3,
        DONE = 3'd4,
        ERR  = 3'd5
    } phase_t;

    typedef enum logic [1:0] {
        SRC_RX   = 2'd0,
        SRC_PROC = 2'd1,
        SRC_TX   = 2'd2,
        SRC_DBG  = 2'd3
    } src_t;

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    phase_t state;
    phase_t state_next;

    logic              owner_req;
    logic              owner_we;
    logic [ADDR_W-1:0] owner_addr;
    logic [DATA_W-1:0] owner_din;
    src_t              owner_src;

    logic owner_win;
    logic dbg_win;
    logic last_dbg;
    logic read_gnt;

    logic             active;
    logic [CNT_W-1:0] idle_cnt;
    logic [CNT_W-1:0] idle_inc;
    logic             timed_out;

    src_t rd_src_q;

    // Select the request presented by whichever client owns the current phase.
    always_comb begin
        owner_req  = 1'b0;
        owner_we   = 1'b0;
        owner_addr = '0;
        owner_din  = '0;
        owner_src  = SRC_RX;
        case (state)
            LOAD: begin
                owner_req  = rx_req;
                owner_we   = 1'b1;
                owner_addr = rx_addr;
                owner_din  = rx_wdata;
                owner_src  = SRC_RX;
            end
            PROC: begin
                owner_req  = proc_req;
                owner_we   = proc_we;
                owner_addr = proc_addr;
                owner_din  = proc_wdata;
                owner_src  = SRC_PROC;
            end
            DUMP: begin
                owner_req  = tx_req;
                owner_we   = 1'b0;
                owner_addr = tx_addr;
                owner_din  = '0;
                owner_src  = SRC_TX;
            end
            default: ;
        endcase
    end

    // Two-way round robin; last_dbg records who won the previous grant.
    always_comb begin
        owner_win = 1'b0;
        dbg_win   = 1'b0;
        if (!reset) begin
            if (owner_req && dbg_req) begin
                owner_win = last_dbg;
                dbg_win   = !last_dbg;
            end else begin
                owner_win = owner_req;
                dbg_win   = dbg_req;
            end
        end
    end

    assign rx_gnt   = owner_win && (state == LOAD);
    assign proc_gnt = owner_win && (state == PROC);
    assign tx_gnt   = owner_win && (state == DUMP);
    assign dbg_gnt  = dbg_win;

    assign bram_ena  = owner_win || dbg_win;
    assign bram_wea  = owner_win ? owner_we : (dbg_win && dbg_we);
    assign bram_addr = dbg_win ? dbg_addr : owner_addr;
    assign bram_din  = dbg_win ? dbg_wdata : owner_din;
    assign read_gnt  = bram_ena && !bram_wea;

    assign rd_data = bram_dout;
    assign rd_src  = rd_src_q;

    // Stall detection: only owner grants count as progress.
    always_comb begin
        active    = (state == LOAD) || (state == PROC) || (state == DUMP);
        idle_inc  = (idle_cnt == '1) ? idle_cnt : idle_cnt + CNT_W'(1);
        timed_out = (TIMEOUT != 0) && active && !owner_win
                    && (idle_inc == CNT_W'(TIMEOUT));
    end

    // Completion pulses win over a coincident timeout.
    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE, ERR: if (start) state_next = LOAD;
            LOAD: begin
                if (rx_done)        state_next = PROC;
                else if (timed_out) state_next = ERR;
            end
            PROC: begin
                if (proc_done)      state_next = DUMP;
                else if (timed_out) state_next = ERR;
            end
            DUMP: begin
                if (tx_done)        state_next = DONE;
                else if (timed_out) state_next = ERR;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_dbg   <= 1'b1;
            idle_cnt   <= '0;
            rd_valid   <= 1'b0;
            rd_src_q   <= SRC_RX;
            proc_start <= 1'b0;
            tx_start   <= 1'b0;
        end else begin
            if (owner_win || dbg_win) begin
                last_dbg <= dbg_win;
            end
            if (!active || (state_next != state) || owner_win) begin
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_inc;
            end
            rd_valid <= read_gnt;
            if (read_gnt) begin
                rd_src_q <= dbg_win ? SRC_DBG : owner_src;
            end
            proc_start <= (state == LOAD) && (state_next == PROC);
            tx_start   <= (state == PROC) && (state_next == DUMP);
        end
    end

    assign phase = state;
    assign done  = (state == DONE);
    assign err   = (state == ERR);

    gnt_onehot: assert property (@(posedge clk) disable iff (reset)
        $onehot0({rx_gnt, proc_gnt, tx_gnt, dbg_gnt}));

endmodule

// File: tb/tb_img_bram_sequencer.sv
// Bench for img_bram_sequencer: directed vector table, corner-case sequences and
// randomized traffic checked against a cycle-level behavioural model.
module tb_img_bram_sequencer;

    localparam int ADDR_W  = 14;
    localparam int DATA_W  = 8;
    localparam int TIMEOUT = 16;
    localparam int DEPTH   = 1 << ADDR_W;
    localparam int NV      = 12;

    logic clk = 1'b0;
    logic reset, start, rx_done, proc_done, tx_done;
    logic rx_req, proc_req, tx_req, dbg_req, proc_we, dbg_we;
    logic [ADDR_W-1:0] rx_addr, proc_addr, tx_addr, dbg_addr, bram_addr;
    logic [DATA_W-1:0] rx_wdata, proc_wdata, dbg_wdata, rd_data, bram_din, bram_dout;
    logic rx_gnt, proc_gnt, tx_gnt, dbg_gnt, rd_valid, bram_ena, bram_wea;
    logic proc_start, tx_start, done, err;
    logic [1:0] rd_src;
    logic [2:0] phase;

    always #5 clk = ~clk;

    img_bram_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .start(start),
        .rx_done(rx_done), .proc_done(proc_done), .tx_done(tx_done),
        .rx_req(rx_req), .proc_req(proc_req), .tx_req(tx_req), .dbg_req(dbg_req),
        .proc_we(proc_we), .dbg_we(dbg_we),
        .rx_addr(rx_addr), .proc_addr(proc_addr), .tx_addr(tx_addr), .dbg_addr(dbg_addr),
        .rx_wdata(rx_wdata), .proc_wdata(proc_wdata), .dbg_wdata(dbg_wdata),
        .rx_gnt(rx_gnt), .proc_gnt(proc_gnt), .tx_gnt(tx_gnt), .dbg_gnt(dbg_gnt),
        .rd_valid(rd_valid), .rd_src(rd_src), .rd_data(rd_data),
        .bram_ena(bram_ena), .bram_wea(bram_wea), .bram_addr(bram_addr),
        .bram_din(bram_din), .bram_dout(bram_dout),
        .phase(phase), .proc_start(proc_start), .tx_start(tx_start),
        .done(done), .err(err)
    );

    // BRAM with one-cycle read latency, zero-initialised
    bit [DATA_W-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        if (bram_ena) begin
            if (bram_wea) mem[bram_addr] <= bram_din;
            else          bram_dout <= mem[bram_addr];
        end
    end

    // Reference model state
    int              m_phase;
    bit              m_last_dbg;
    int              m_idle;
    bit              m_rv;
    int              m_rsrc;
    bit [DATA_W-1:0] m_rdata;
    bit              m_ps, m_ts;
    bit [DATA_W-1:0] m_mem [DEPTH];

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        bit        start;
        bit [3:0]  req;
        bit        we;
        bit [2:0]  dn;
        bit [13:0] addr;
        bit [7:0]  wd;
        bit [2:0]  ph;
        bit [3:0]  gnt;
        bit        wea;
        bit        rv;
        bit [1:0]  rsrc;
        bit [7:0]  rdat;
        bit        ps;
        bit        ts;
    } vec_t;

    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic clear_inputs();
        reset = 1'b0; start = 1'b0;
        rx_done = 1'b0; proc_done = 1'b0; tx_done = 1'b0;
        rx_req = 1'b0; proc_req = 1'b0; tx_req = 1'b0; dbg_req = 1'b0;
        proc_we = 1'b0; dbg_we = 1'b0;
        rx_addr = '0; proc_addr = '0; tx_addr = '0; dbg_addr = '0;
        rx_wdata = '0; proc_wdata = '0; dbg_wdata = '0;
    endtask

    task automatic model_reset();
        m_phase = 0; m_last_dbg = 1'b1; m_idle = 0;
        m_rv = 1'b0; m_rsrc = 0; m_ps = 1'b0; m_ts = 1'b0;
    endtask

    // Check this cycle's outputs against the model, then advance the model past the clock edge.
    task automatic model_cycle();
        int own, win, nxt;
        bit wr;
        bit [3:0] reqs;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        reqs = {dbg_req, tx_req, proc_req, rx_req};
        own  = (m_phase >= 1 && m_phase <= 3) ? m_phase - 1 : -1;
        win  = -1;
        if (!reset) begin
            if (own >= 0 && reqs[own] && dbg_req) win = m_last_dbg ? own : 3;
            else if (own >= 0 && reqs[own])       win = own;
            else if (dbg_req)                     win = 3;
        end
        case (win)
            0:       begin a = rx_addr;   d = rx_wdata;   wr = 1'b1;    end
            1:       begin a = proc_addr; d = proc_wdata; wr = proc_we; end
            2:       begin a = tx_addr;   d = '0;         wr = 1'b0;    end
            3:       begin a = dbg_addr;  d = dbg_wdata;  wr = dbg_we;  end
            default: begin a = '0;        d = '0;         wr = 1'b0;    end
        endcase
        chk("gnt", {dbg_gnt, tx_gnt, proc_gnt, rx_gnt}, (win >= 0) ? (32'd1 << win) : 32'd0);
        chk("bram_ena", bram_ena, win >= 0);
        chk("bram_wea", bram_wea, wr);
        if (win >= 0) chk("bram_addr", bram_addr, a);
        if (wr)       chk("bram_din", bram_din, d);
        chk("phase", phase, m_phase);
        chk("rd_valid", rd_valid, m_rv);
        chk("rd_src", rd_src, m_rsrc);
        if (m_rv) chk("rd_data", rd_data, m_rdata);
        chk("proc_start", proc_start, m_ps);
        chk("tx_start", tx_start, m_ts);
        chk("done", done, m_phase == 4);
        chk("err", err, m_phase == 5);

        if (reset) begin
            model_reset();
            return;
        end
        m_rv = 1'b0;
        if (win >= 0) begin
            m_last_dbg = (win == 3);
            if (wr) m_mem[a] = d;
            else begin
                m_rv    = 1'b1;
                m_rsrc  = win;
                m_rdata = m_mem[a];
            end
        end
        nxt = m_phase;
        case (m_phase)
            0, 4, 5: if (start)     nxt = 1;
            1:       if (rx_done)   nxt = 2;
            2:       if (proc_done) nxt = 3;
            3:       if (tx_done)   nxt = 4;
            default: nxt = 0;
        endcase
        if (own >= 0 && nxt == m_phase) begin
            m_idle = (win == own) ? 0 : m_idle + 1;
            if (m_idle == TIMEOUT) nxt = 5;
        end else begin
            m_idle = 0;
        end
        m_ps    = (m_phase == 1 && nxt == 2);
        m_ts    = (m_phase == 2 && nxt == 3);
        m_phase = nxt;
    endtask

    // Inputs are applied just after a falling edge; outputs are sampled before the rising edge.
    task automatic cycle();
        #1;
        model_cycle();
        @(negedge clk);
    endtask

    function automatic logic [ADDR_W-1:0] pick_addr();
        if ($urandom_range(0, 7) == 0) return '1;
        return ADDR_W'($urandom_range(0, 15));
    endfunction

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // start req(dbg,tx,proc,rx) we dn(tx,proc,rx) addr wd | ph gnt wea rv rsrc rdat ps ts
        vecs[0]  = '{1'b0, 4'b0000, 1'b0, 3'b000, 14'd0,     8'h00, 3'd0, 4'b0000, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 4'b0000, 1'b0, 3'b000, 14'd0,     8'h00, 3'd0, 4'b0000, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 4'b0001, 1'b0, 3'b000, 14'd0,     8'hA5, 3'd1, 4'b0001, 1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 4'b0001, 1'b0, 3'b000, 14'd16383, 8'h3C, 3'd1, 4'b0001, 1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 4'b0000, 1'b0, 3'b001, 14'd0,     8'h00, 3'd1, 4'b0000, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 4'b0010, 1'b0, 3'b000, 14'd0,     8'h00, 3'd2, 4'b0010, 1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 4'b0000, 1'b0, 3'b000, 14'd0,     8'h00, 3'd2, 4'b0000, 1'b0, 1'b1, 2'd1, 8'hA5, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 4'b0010, 1'b0, 3'b010, 14'd16383, 8'h00, 3'd2, 4'b0010, 1'b0, 1'b0, 2'd1, 8'h00, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 4'b0000, 1'b0, 3'b000, 14'd0,     8'h00, 3'd3, 4'b0000, 1'b0, 1'b1, 2'd1, 8'h3C, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 4'b0000, 1'b0, 3'b100, 14'd0,     8'h00, 3'd3, 4'b0000, 1'b0, 1'b0, 2'd1, 8'h00, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 4'b0000, 1'b0, 3'b001, 14'd0,     8'h00, 3'd4, 4'b0000, 1'b0, 1'b0, 2'd1, 8'h00, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 4'b0000, 1'b0, 3'b000, 14'd0,     8'h00, 3'd4, 4'b0000, 1'b0, 1'b0, 2'd1, 8'h00, 1'b0, 1'b0};

        clear_inputs();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        model_reset();

        // Directed frame: load, process, dump, done
        for (int i = 0; i < NV; i++) begin
            clear_inputs();
            start = vecs[i].start;
            {dbg_req, tx_req, proc_req, rx_req} = vecs[i].req;
            proc_we = vecs[i].we; dbg_we = vecs[i].we;
            {tx_done, proc_done, rx_done} = vecs[i].dn;
            rx_addr = vecs[i].addr; proc_addr = vecs[i].addr;
            tx_addr = vecs[i].addr; dbg_addr = vecs[i].addr;
            rx_wdata = vecs[i].wd; proc_wdata = vecs[i].wd; dbg_wdata = vecs[i].wd;
            #1;
            chk($sformatf("vec%0d.phase", i), phase, vecs[i].ph);
            chk($sformatf("vec%0d.gnt", i), {dbg_gnt, tx_gnt, proc_gnt, rx_gnt}, vecs[i].gnt);
            chk($sformatf("vec%0d.wea", i), bram_wea, vecs[i].wea);
            chk($sformatf("vec%0d.rd_valid", i), rd_valid, vecs[i].rv);
            chk($sformatf("vec%0d.rd_src", i), rd_src, vecs[i].rsrc);
            if (vecs[i].rv) chk($sformatf("vec%0d.rd_data", i), rd_data, vecs[i].rdat);
            chk($sformatf("vec%0d.proc_start", i), proc_start, vecs[i].ps);
            chk($sformatf("vec%0d.tx_start", i), tx_start, vecs[i].ts);
            chk($sformatf("vec%0d.done", i), done, vecs[i].ph == 3'd4);
            chk($sformatf("vec%0d.err", i), err, vecs[i].ph == 3'd5);
            cycle();
        end

        // dbg write in DONE leaves the pointer on dbg, so rx wins the first LOAD contention
        clear_inputs(); dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 14'd5; dbg_wdata = 8'h77;
        #1; chk("dbg_write_in_done", dbg_gnt, 1'b1);
        cycle();
        clear_inputs(); start = 1'b1;
        cycle();
        for (int k = 0; k < 4; k++) begin
            clear_inputs();
            rx_req = 1'b1; rx_addr = 14'(100 + k); rx_wdata = 8'(k);
            dbg_req = 1'b1; dbg_addr = 14'd5;
            #1; chk($sformatf("rr_contention%0d", k), {dbg_gnt, tx_gnt, proc_gnt, rx_gnt},
                    (k % 2 == 0) ? 4'b0001 : 4'b1000);
            cycle();
        end

        // tx request held from LOAD through to DUMP
        for (int k = 0; k < 2; k++) begin
            clear_inputs(); tx_req = 1'b1; tx_addr = 14'd5;
            #1; chk("tx_gnt_in_load", tx_gnt, 1'b0);
            cycle();
        end
        clear_inputs(); tx_req = 1'b1; tx_addr = 14'd5; rx_done = 1'b1;
        cycle();
        clear_inputs(); tx_req = 1'b1; tx_addr = 14'd5; proc_done = 1'b1;
        #1; chk("tx_gnt_in_proc", tx_gnt, 1'b0);
        cycle();
        clear_inputs(); tx_req = 1'b1; tx_addr = 14'd5;
        #1;
        chk("dump_phase", phase, 3'd3);
        chk("dump_tx_start", tx_start, 1'b1);
        chk("dump_tx_gnt", tx_gnt, 1'b1);
        cycle();
        clear_inputs();
        #1;
        chk("tx_rd_valid", rd_valid, 1'b1);
        chk("tx_rd_src", rd_src, 2'd2);
        chk("tx_rd_data", rd_data, 8'h77);
        cycle();

        // Timeout boundaries: done pulse beats the timeout in LOAD, dbg grants do not stop it in PROC
        clear_inputs(); tx_done = 1'b1;
        cycle();
        clear_inputs();
        #1; chk("done_flag", done, 1'b1); chk("done_phase", phase, 3'd4);
        cycle();
        clear_inputs(); start = 1'b1;
        cycle();
        for (int k = 0; k < TIMEOUT - 1; k++) begin
            clear_inputs();
            #1; chk("load_idle_phase", phase, 3'd1);
            cycle();
        end
        clear_inputs(); rx_done = 1'b1;
        #1; chk("load_last_idle_phase", phase, 3'd1);
        cycle();
        for (int k = 0; k < TIMEOUT; k++) begin
            clear_inputs(); dbg_req = 1'b1; dbg_addr = 14'd5;
            #1; chk("proc_idle_phase", phase, 3'd2); chk("proc_idle_dbg_gnt", dbg_gnt, 1'b1);
            cycle();
        end
        clear_inputs(); dbg_req = 1'b1; dbg_addr = 14'd0;
        #1;
        chk("timeout_phase", phase, 3'd5);
        chk("timeout_err", err, 1'b1);
        chk("err_dbg_gnt", dbg_gnt, 1'b1);
        cycle();
        clear_inputs(); start = 1'b1;
        #1; chk("err_rd_src", rd_src, 2'd3); chk("err_rd_data", rd_data, 8'hA5);
        cycle();
        clear_inputs();
        #1; chk("restart_phase", phase, 3'd1); chk("restart_err", err, 1'b0);
        cycle();

        // Reset straight after a granted dbg read drops the pending read
        clear_inputs(); dbg_req = 1'b1; dbg_addr = 14'd16383;
        #1; chk("pre_reset_dbg_gnt", dbg_gnt, 1'b1);
        cycle();
        clear_inputs(); reset = 1'b1;
        #1; chk("reset_cycle_rd_valid", rd_valid, 1'b1);
        cycle();
        clear_inputs();
        #1; chk("post_reset_rd_valid", rd_valid, 1'b0); chk("post_reset_phase", phase, 3'd0);
        cycle();

        // Randomized traffic; every third window of 200 cycles starves the owners to provoke timeouts
        for (int k = 0; k < 3000; k++) begin
            bit quiet;
            quiet      = ((k / 200) % 3 == 2);
            reset      = ($urandom_range(0, 199) == 0);
            start      = ($urandom_range(0, 15) == 0);
            rx_done    = ($urandom_range(0, 9) == 0);
            proc_done  = ($urandom_range(0, 9) == 0);
            tx_done    = ($urandom_range(0, 9) == 0);
            rx_req     = !quiet && ($urandom_range(0, 1) == 1);
            proc_req   = !quiet && ($urandom_range(0, 1) == 1);
            tx_req     = !quiet && ($urandom_range(0, 1) == 1);
            dbg_req    = ($urandom_range(0, 2) == 0);
            proc_we    = ($urandom_range(0, 1) == 1);
            dbg_we     = ($urandom_range(0, 1) == 1);
            rx_addr    = pick_addr();
            proc_addr  = pick_addr();
            tx_addr    = pick_addr();
            dbg_addr   = pick_addr();
            rx_wdata   = 8'($urandom);
            proc_wdata = 8'($urandom);
            dbg_wdata  = 8'($urandom);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/img_bram_sequencer.md
Name: img_bram_sequencer

Overview:
Owns the single-port image BRAM (2**ADDR_W x DATA_W, 1-cycle read latency), which is shared by the UART image receiver, the image processing engine and the UART image transmitter.
Sequences the frame phases IDLE -> LOAD -> PROC -> DUMP -> DONE.
Grants the BRAM only to the current phase owner, round-robin with a debug/host port that may access the BRAM in any phase.
Also flags phases that stall.

Parameters:
ADDR_W, 14, BRAM address width
DATA_W, 8, BRAM data width
TIMEOUT, 2_000_000, cycles without owner grant before ERR; 0 disables

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  pulse; begins a frame from IDLE, DONE or ERR
rx_done, proc_done, tx_done  in  1 each  completion pulses from each phase owner
rx_req, proc_req, tx_req, dbg_req  in  1 each  access requests
proc_we, dbg_we  in  1 each  write enables (rx always writes; tx always reads)
rx_addr, proc_addr, tx_addr, dbg_addr  in  ADDR_W each  request addresses
rx_wdata, proc_wdata, dbg_wdata  in  DATA_W each  write data
rx_gnt, proc_gnt, tx_gnt, dbg_gnt  out  1 each  combinational grant, same cycle as request
rd_valid  out  1  read data valid, one cycle after a granted read
rd_src  out  2  owner of rd_data: 0=rx, 1=proc, 2=tx, 3=dbg
rd_data  out  DATA_W  equals bram_dout
bram_ena, bram_wea  out  1 each  BRAM enable / write enable
bram_addr  out  ADDR_W  BRAM address
bram_din  out  DATA_W  BRAM write data
bram_dout  in  DATA_W  BRAM read data
phase  out  3  0=IDLE 1=LOAD 2=PROC 3=DUMP 4=DONE 5=ERR
proc_start, tx_start  out  1 each  one-cycle pulse on entering PROC / DUMP
done  out  1  high while in DONE
err  out  1  high while in ERR

Behaviour:
- Reset: phase=IDLE; rd_valid=0, rd_src=0, proc_start=0, tx_start=0, done=0, err=0; RR pointer=dbg, so the owner wins the first contention; timeout counter=0. Reset mid-frame aborts to IDLE and drops any pending read, forcing rd_valid=0 next cycle.
- Phase FSM:
  - IDLE/DONE/ERR --start--> LOAD.
  - LOAD --rx_done--> PROC, with proc_start pulsed in the first PROC cycle.
  - PROC --proc_done--> DUMP, with tx_start pulsed in the first DUMP cycle.
  - DUMP --tx_done--> DONE.
  - Done pulses arriving outside their own phase are ignored. start outside IDLE/DONE/ERR is ignored.
- Owner: LOAD=rx, PROC=proc, DUMP=tx; no owner in IDLE/DONE/ERR. Requests from non-owner clients are never granted and are held by the client.
- Arbitration each cycle uses the phase at the start of the cycle:
  - Only the owner requests: owner is granted.
  - Only dbg requests: dbg is granted.
  - Both request: the one not granted last is granted. The pointer updates on every grant.
  - At most one gnt is high per cycle.
- The granted request drives bram_ena=1, bram_addr, bram_din and bram_wea combinationally in the same cycle. With no grant, bram_ena=0 and bram_wea=0.
- Reads: a granted read in cycle N gives rd_valid=1 with rd_src=winner in cycle N+1, and rd_data=bram_dout. A read granted in the last cycle of a phase still returns rd_valid next cycle, even though the phase has changed.
- Clients hold req, addr and data until gnt. A client may deassert req before gnt with no side effect.
- Timeout counter (LOAD/PROC/DUMP only):
  - Clears on phase entry and on every owner grant; increments otherwise, saturating.
  - When it reaches TIMEOUT (and TIMEOUT != 0), the next state is ERR.
  - A done pulse in the same cycle takes priority over the timeout.
  - dbg grants do not clear the counter.
- Simultaneous events: a done pulse and an owner grant in the same cycle both complete; the access is performed and the phase advances next cycle.

Test Plan:
- Reset, then start; rx writes 0xA5 to addr 0 and 0x3C to addr 16383; rx_done; proc reads addr 0 -> rx_gnt is high on each write cycle with bram_wea=1; phase goes 1->2; proc_start pulses once; rd_valid with rd_src=1 and rd_data=0xA5 one cycle after proc_gnt.
- LOAD with rx_req and dbg_req both held for 4 cycles -> grants alternate rx, dbg, rx, dbg, and never overlap.
- tx_req asserted during LOAD -> tx_gnt stays 0 until DUMP; after proc_done, tx_start pulses and tx_gnt is high the same cycle as tx_req.
- TIMEOUT=16, enter PROC with no proc_req -> phase=5 and err=1 after 16 idle cycles; dbg reads still granted while in ERR; start -> phase=1 and err=0.
- proc_done coinciding with a granted proc read -> rd_valid with rd_src=1 in the first DUMP cycle.
- Reset asserted the cycle after a dbg read grant -> rd_valid=0 and phase=0 on the next cycle.
- tx_done -> done=1, phase=4; rx_done pulse while in DONE -> no state change.
